// File: rtl/regbus_pkg.sv
// Shared definitions for the system register bus initiator: bus widths,
// FSM state encoding, the command record and a latency-load helper.
package regbus_pkg;

   localparam int REGBUS_ADDR_W  = 4;
   localparam int REGBUS_DATA_W  = 8;
   localparam int REGBUS_COUNT_W = 4;
   localparam int REGBUS_LAT_W   = 3;

   typedef enum logic [2:0] {
      IDLE,
      WSTB,
      RSTB,
      RWAIT,
      RESP
   } regbus_state_e;

   typedef struct packed {
      logic                      write;
      logic [REGBUS_ADDR_W-1:0]  addr;
      logic [REGBUS_DATA_W-1:0]  data;
      logic [REGBUS_COUNT_W-1:0] count;
   } regbus_cmd_t;

   // Value loaded into the latency counter so that it reaches zero on the
   // cycle the responder data is valid.
   function automatic logic [REGBUS_LAT_W-1:0] lat_load(input int latency);
      return REGBUS_LAT_W'(latency - 1);
   endfunction

endpackage

// File: rtl/regbus_initiator.sv
// Register bus initiator: converts valid/ready commands into single-cycle
// read/write strobes on the 4-bit-address / 8-bit-data register bus and
// returns read data (single or burst) on a valid/ready response channel.
// Optional build macro REGBUS_WRITE_READBACK_EN: every write is followed by a
// read of the same address whose data is returned as one response.
module regbus_initiator
   import regbus_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int ADDR_W       = REGBUS_ADDR_W
)(
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_W-1:0]         cmd_addr,
   input  logic [REGBUS_DATA_W-1:0]  cmd_data,
   input  logic [REGBUS_COUNT_W-1:0] cmd_count,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [REGBUS_DATA_W-1:0]  rsp_data,
   output logic                      rsp_last,
   output logic [ADDR_W-1:0]         a,
   output logic [REGBUS_DATA_W-1:0]  d_d,
   input  logic [REGBUS_DATA_W-1:0]  d_q,
   output logic                      read_strobe,
   output logic                      write_strobe,
   output logic                      busy
);

   localparam logic [REGBUS_LAT_W-1:0]   LAT_LOAD  = lat_load(READ_LATENCY);
   localparam logic [ADDR_W-1:0]         ADDR_STEP = ADDR_W'(1);
   localparam logic [REGBUS_COUNT_W-1:0] BEAT_STEP = REGBUS_COUNT_W'(1);
   localparam logic [REGBUS_LAT_W-1:0]   LAT_STEP  = REGBUS_LAT_W'(1);

   regbus_state_e               r_state;
   logic                        r_cmd_ready;
   logic                        r_busy;
   logic                        r_read_strobe;
   logic                        r_write_strobe;
   logic [ADDR_W-1:0]           r_a;
   logic [REGBUS_DATA_W-1:0]    r_d_d;
   logic [REGBUS_COUNT_W-1:0]   r_beats;
   logic [REGBUS_LAT_W-1:0]     r_lat_cnt;
   logic                        r_rsp_valid;
   logic [REGBUS_DATA_W-1:0]    r_rsp_data;
   logic                        r_rsp_last;
   logic                        w_accept;
   logic                        w_rsp_fire;

   assign w_accept   = r_cmd_ready & cmd_valid;
   assign w_rsp_fire = r_rsp_valid & rsp_ready;

   // Command sequencer; every bus and handshake output is a register so the
   // strobes are glitch-free single-cycle pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= IDLE;
         r_cmd_ready    <= 1'b0;
         r_busy         <= 1'b0;
         r_read_strobe  <= 1'b0;
         r_write_strobe <= 1'b0;
         r_a            <= '0;
         r_d_d          <= '0;
         r_beats        <= '0;
         r_lat_cnt      <= '0;
         r_rsp_valid    <= 1'b0;
         r_rsp_data     <= '0;
         r_rsp_last     <= 1'b0;
      end else begin
         // Strobes are pulses: cleared unless a transition below re-arms one.
         r_read_strobe  <= 1'b0;
         r_write_strobe <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
               if (w_accept) begin
                  r_a         <= cmd_addr;
                  r_d_d       <= cmd_data;
                  r_beats     <= cmd_count;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (cmd_write) begin
                     r_state        <= WSTB;
                     r_write_strobe <= 1'b1;
                  end else begin
                     r_state       <= RSTB;
                     r_read_strobe <= 1'b1;
                  end
               end
            end
            WSTB: begin
`ifdef REGBUS_WRITE_READBACK_EN
               // Read the just-written register back as a one-beat burst.
               r_beats       <= '0;
               r_state       <= RSTB;
               r_read_strobe <= 1'b1;
`else
               r_state     <= IDLE;
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
`endif
            end
            RSTB: begin
               r_lat_cnt <= LAT_LOAD;
               r_state   <= RWAIT;
            end
            RWAIT: begin
               if (r_lat_cnt == '0) begin
                  r_rsp_data  <= d_q;
                  r_rsp_last  <= (r_beats == '0);
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end else begin
                  r_lat_cnt <= r_lat_cnt - LAT_STEP;
               end
            end
            RESP: begin
               if (w_rsp_fire) begin
                  r_rsp_valid <= 1'b0;
                  if (r_beats == '0) begin
                     r_state     <= IDLE;
                     r_cmd_ready <= 1'b1;
                     r_busy      <= 1'b0;
                  end else begin
                     // Address wraps naturally at the top of the map.
                     r_beats       <= r_beats - BEAT_STEP;
                     r_a           <= r_a + ADDR_STEP;
                     r_state       <= RSTB;
                     r_read_strobe <= 1'b1;
                  end
               end
            end
            default: begin
               r_state     <= IDLE;
               r_cmd_ready <= 1'b0;
               r_busy      <= 1'b0;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready    = r_cmd_ready;
   assign busy         = r_busy;
   assign read_strobe  = r_read_strobe;
   assign write_strobe = r_write_strobe;
   assign a            = r_a;
   assign d_d          = r_d_d;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_data     = r_rsp_data;
   assign rsp_last     = r_rsp_last;

endmodule

// File: tb/tb_regbus_initiator.sv
// Self-checking bench for regbus_initiator: directed steps plus a randomized
// command phase, compared against a transaction-level model of the bus.
module tb_regbus_initiator;
   import regbus_pkg::*;

   localparam int LAT = 1;

   logic       clk;
   logic       reset_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_data;
   logic [3:0] cmd_count;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_last;
   logic [3:0] a;
   logic [7:0] d_d;
   logic [7:0] d_q;
   logic       read_strobe;
   logic       write_strobe;
   logic       busy;

   regbus_initiator #(.READ_LATENCY(LAT), .ADDR_W(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_count(cmd_count),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_last(rsp_last), .a(a), .d_d(d_d), .d_q(d_q),
      .read_strobe(read_strobe), .write_strobe(write_strobe), .busy(busy)
   );

   typedef struct {
      bit         wr;
      logic [3:0] addr;
      logic [7:0] data;
      int         cyc;
   } ev_t;

   typedef struct {
      logic [7:0] data;
      logic       last;
      int         cyc;
   } rsp_t;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   rdy_mode = 0;
   int   proto_viol = 0;
   logic prev_rd = 1'b0;
   logic prev_wr = 1'b0;
   logic stb_bad;

   ev_t  got_ev[$];
   ev_t  exp_ev[$];
   rsp_t got_rsp[$];
   rsp_t exp_rsp[$];
   int   ev_base = 0, xev_base = 0, rsp_base = 0, xrsp_base = 0;

   logic [7:0] ref_mem [16];
   logic [7:0] dev_mem [16];
   logic [7:0] rd_pipe [LAT];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Responder: registered memory, read data valid exactly LAT cycles after the strobe.
   always @(posedge clk) begin
      if (write_strobe) dev_mem[a] <= d_d;
      rd_pipe[0] <= read_strobe ? dev_mem[a] : 8'hEE;
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign d_q = rd_pipe[LAT-1];

   // Response consumer: held high, held low, or random.
   initial begin
      rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

`ifdef REGBUS_WRITE_READBACK_EN
   assign stb_bad = (read_strobe && write_strobe) || (read_strobe && prev_rd) ||
                    (write_strobe && prev_wr);
`else
   assign stb_bad = (read_strobe && write_strobe) ||
                    ((read_strobe || write_strobe) && (prev_rd || prev_wr));
`endif

   // Bus monitor: logs strobes and response handshakes, counts strobe-rule violations.
   always @(negedge clk) begin
      if (write_strobe) got_ev.push_back('{wr: 1'b1, addr: a, data: d_d, cyc: cyc});
      if (read_strobe)  got_ev.push_back('{wr: 1'b0, addr: a, data: 8'h00, cyc: cyc});
      if (rsp_valid && rsp_ready)
         got_rsp.push_back('{data: rsp_data, last: rsp_last, cyc: cyc});
      if (stb_bad) proto_viol <= proto_viol + 1;
      prev_rd <= read_strobe;
      prev_wr <= write_strobe;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Transaction-level model: expected strobes and responses for one command.
   task automatic model_cmd(input bit w, input logic [3:0] ad, input logic [7:0] dt,
                            input logic [3:0] cnt);
      logic [3:0] ra;
      if (w) begin
         exp_ev.push_back('{wr: 1'b1, addr: ad, data: dt, cyc: 0});
         ref_mem[ad] = dt;
`ifdef REGBUS_WRITE_READBACK_EN
         exp_ev.push_back('{wr: 1'b0, addr: ad, data: 8'h00, cyc: 0});
         exp_rsp.push_back('{data: dt, last: 1'b1, cyc: 0});
`endif
      end else begin
         for (int i = 0; i <= int'(cnt); i++) begin
            ra = ad + 4'(i);
            exp_ev.push_back('{wr: 1'b0, addr: ra, data: 8'h00, cyc: 0});
            exp_rsp.push_back('{data: ref_mem[ra], last: (i == int'(cnt)), cyc: 0});
         end
      end
   endtask

   task automatic send_cmd(input bit w, input logic [3:0] ad, input logic [7:0] dt,
                           input logic [3:0] cnt, input bit do_model, output int acc);
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = ad;
      cmd_data  = dt;
      cmd_count = cnt;
      acc = -1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (cmd_ready) begin
            acc = cyc;
            break;
         end
      end
      check("cmd_accepted", 32'(acc >= 0), 32'd1);
      if (do_model && acc >= 0) model_cmd(w, ad, dt, cnt);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic compare_seg(input string tag);
      int ne, nr;
      ne = exp_ev.size() - xev_base;
      nr = exp_rsp.size() - xrsp_base;
      check({tag, "_strobe_count"}, 32'(got_ev.size() - ev_base), 32'(ne));
      check({tag, "_rsp_count"}, 32'(got_rsp.size() - rsp_base), 32'(nr));
      for (int i = 0; i < ne; i++) begin
         if (ev_base + i < got_ev.size()) begin
            check({tag, "_strobe_kind"}, 32'(got_ev[ev_base+i].wr), 32'(exp_ev[xev_base+i].wr));
            check({tag, "_strobe_addr"}, 32'(got_ev[ev_base+i].addr), 32'(exp_ev[xev_base+i].addr));
            if (exp_ev[xev_base+i].wr)
               check({tag, "_strobe_data"}, 32'(got_ev[ev_base+i].data),
                     32'(exp_ev[xev_base+i].data));
         end
      end
      for (int i = 0; i < nr; i++) begin
         if (rsp_base + i < got_rsp.size()) begin
            check({tag, "_rsp_data"}, 32'(got_rsp[rsp_base+i].data), 32'(exp_rsp[xrsp_base+i].data));
            check({tag, "_rsp_last"}, 32'(got_rsp[rsp_base+i].last), 32'(exp_rsp[xrsp_base+i].last));
         end
      end
      ev_base   = got_ev.size();
      xev_base  = exp_ev.size();
      rsp_base  = got_rsp.size();
      xrsp_base = exp_rsp.size();
   endtask

   function automatic logic [31:0] out_vec();
      return 32'({cmd_ready, rsp_valid, rsp_last, rsp_data, a, d_d,
                  read_strobe, write_strobe, busy});
   endfunction

   initial begin
      int          acc, e0, r0;
      bit          found;
      logic [7:0]  held_data;
      logic        held_last;
      logic [7:0]  wdata [16];
      regbus_cmd_t c;

      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 4'h0;
      cmd_data  = 8'h00;
      cmd_count = 4'h0;

      // Step: reset state and cmd_ready rising on the first edge after release.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", out_vec(), 32'd0);
      reset_n = 1'b1;
      #1;
      check("ready_before_edge", 32'(cmd_ready), 32'd0);
      @(posedge clk);
      #1;
      check("ready_after_edge", 32'(cmd_ready), 32'd1);

      // Step: single write of A5 to address 2.
      send_cmd(1'b1, 4'h2, 8'hA5, 4'h0, 1'b1, acc);
      @(negedge clk);
      check("wr_strobe_on", 32'(write_strobe), 32'd1);
      check("wr_addr", 32'(a), 32'h2);
      check("wr_data", 32'(d_d), 32'hA5);
      check("wr_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("wr_strobe_off", 32'(write_strobe), 32'd0);
`ifndef REGBUS_WRITE_READBACK_EN
      check("wr_ready_again", 32'(cmd_ready), 32'd1);
      check("wr_still_no_rsp", 32'(rsp_valid), 32'd0);
`endif
      wait_idle("write1");
      compare_seg("write1");

      // Step: back-to-back writes to every address with cmd_valid held high.
      for (int i = 0; i < 16; i++) wdata[i] = 8'($urandom);
      wdata[0] = 8'h42;
      wdata[1] = 8'h73;
      e0 = got_ev.size();
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_count = 4'h0;
      for (int i = 0; i < 16; i++) begin
         cmd_addr = 4'(i);
         cmd_data = wdata[i];
         found = 1'b0;
         for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
               found = 1'b1;
               break;
            end
         end
         check("b2b_accepted", 32'(found), 32'd1);
         if (found) model_cmd(1'b1, 4'(i), wdata[i], 4'h0);
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      wait_idle("b2b");
`ifndef REGBUS_WRITE_READBACK_EN
      for (int i = 1; i < 16; i++)
         if (e0 + i < got_ev.size())
            check("b2b_spacing", 32'(got_ev[e0+i].cyc - got_ev[e0+i-1].cyc), 32'd2);
`endif
      compare_seg("b2b");

      // Step: single read of address 0, response two cycles after the strobe.
      e0 = got_ev.size();
      r0 = got_rsp.size();
      send_cmd(1'b0, 4'h0, 8'h00, 4'h0, 1'b1, acc);
      wait_idle("rd1");
      if (got_ev.size() > e0 && got_rsp.size() > r0) begin
         check("rd1_strobe_cycle", 32'(got_ev[e0].cyc - acc), 32'd1);
         check("rd1_latency", 32'(got_rsp[r0].cyc - got_ev[e0].cyc), 32'(1 + LAT));
         check("rd1_data", 32'(got_rsp[r0].data), 32'h42);
      end
      compare_seg("rd1");

      // Step: 4-beat burst across the top of the address map.
      send_cmd(1'b0, 4'hE, 8'h00, 4'h3, 1'b1, acc);
      wait_idle("wrap");
      compare_seg("wrap");

      // Step: backpressure held for 10 cycles on beat 2.
      send_cmd(1'b0, 4'h4, 8'h00, 4'h3, 1'b1, acc);
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            found = 1'b1;
            break;
         end
      end
      check("bp_beat1_seen", 32'(found), 32'd1);
      rdy_mode = 1;
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            found = 1'b1;
            break;
         end
      end
      check("bp_beat2_seen", 32'(found), 32'd1);
      held_data = rsp_data;
      held_last = rsp_last;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_valid_held", 32'(rsp_valid), 32'd1);
         check("bp_data_held", 32'(rsp_data), 32'(held_data));
         check("bp_last_held", 32'(rsp_last), 32'(held_last));
         check("bp_no_strobe", 32'(read_strobe), 32'd0);
      end
      rdy_mode = 0;
      wait_idle("bp");
      compare_seg("bp");

      // Step: reset in the wait phase of the first beat of a 4-beat burst.
      send_cmd(1'b0, 4'h5, 8'h00, 4'h3, 1'b0, acc);
      exp_ev.push_back('{wr: 1'b0, addr: 4'h5, data: 8'h00, cyc: 0});
      @(negedge clk);
      check("rst_first_strobe", 32'(read_strobe), 32'd1);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_async_outputs", out_vec(), 32'd0);
      repeat (3) @(negedge clk);
      check("rst_held_outputs", out_vec(), 32'd0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_no_rsp", 32'(rsp_valid), 32'd0);
      wait_idle("rst");
      compare_seg("rst");
      r0 = got_rsp.size();
      send_cmd(1'b0, 4'h1, 8'h00, 4'h0, 1'b1, acc);
      wait_idle("rst_rd");
      if (got_rsp.size() > r0) check("rst_rd_data", 32'(got_rsp[r0].data), 32'h73);
      compare_seg("rst_rd");

      // Step: randomized command stream with random response backpressure.
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         c.write = ($urandom_range(0, 3) == 0);
         c.addr  = 4'($urandom);
         c.data  = 8'($urandom);
         c.count = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         send_cmd(c.write, c.addr, c.data, c.count, 1'b1, acc);
      end
      wait_idle("rand");
      rdy_mode = 0;
      repeat (2) @(negedge clk);
      compare_seg("rand");

      check("strobe_rules", 32'(proto_viol), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
